delta_pulse_gen: RTL and testbench
==================================

DELTA_PULSE_GEN -- requirements
Module: delta_pulse_gen

Interface
REQ-001 Parameter: none. All widths SHALL come from the shared package constants.
REQ-002 The ports SHALL be:
- clk  in  1  system clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_live  in  1  live gate; generation is allowed only while high
- user_ena  in  1  register enable; low stops generation
- gen_start  in  1  single-cycle start request
- gen_et_amp  in  16  ET pulse amplitude
- gen_veto_ptn  in  32  veto bits driven during a pulse
- gen_period  in  9  cycles from one pulse to the next
- gen_npulse  in  16  pulses per run; 0 means continuous
- out_et  out  17  ET stream; bit16 is the valid flag, bits15:0 the amplitude
- out_veto  out  32  veto stream
- out_busy  out  1  run in progress
- out_done  out  1  single-cycle run-complete strobe
- npulse_sent  out  16  pulses emitted in the current or last run

Function
REQ-003 The FSM SHALL have the states IDLE, GUARD, PULSE, GAP and DONE.
REQ-004 In IDLE, when gen_start=1, in_live=1 and user_ena=1:
- gen_et_amp, gen_veto_ptn, gen_period and gen_npulse SHALL be latched.
- npulse_sent SHALL clear to 0.
- The FSM SHALL go to GUARD.
REQ-005 GUARD SHALL last exactly 1 cycle with zero outputs, then go to PULSE.
REQ-006 The first pulse SHALL appear on the outputs exactly 2 cycles after the cycle in which gen_start is sampled high.
REQ-007 The PULSE state SHALL last exactly 1 cycle.
- It SHALL drive out_et={1'b1, amp} and out_veto=ptn.
- This applies even when amp=0 or ptn=0.
- npulse_sent SHALL increment, saturating at 16'hFFFF.
REQ-008 Outside PULSE, out_et and out_veto SHALL be all-zero.
REQ-009 The pulse-to-pulse spacing SHALL equal max(gen_period, 2) cycles, so every pulse has a zero cycle on each side.
- Values 0 and 1 SHALL be clamped to 2.
REQ-010 GAP SHALL hold for spacing-1 cycles, then go to PULSE.
- If gen_npulse≠0 and npulse_sent has reached gen_npulse, GAP SHALL go to DONE after 1 cycle instead.
REQ-011 DONE SHALL assert out_done for exactly 1 cycle, then go to IDLE.
REQ-012 out_busy SHALL be 1 in GUARD, PULSE and GAP, and 0 in IDLE and DONE.
REQ-013 gen_start while out_busy=1 SHALL be ignored.
- A change to any gen_* input mid-run SHALL have no effect until the next start.
REQ-014 If user_ena is low when a PULSE would begin, no pulse SHALL be emitted and the FSM SHALL go to DONE.
- This is the graceful stop for continuous mode.
REQ-015 in_live falling in any busy state SHALL abort the run.
- The FSM SHALL return to IDLE on the next cycle with zero outputs and no out_done.
- npulse_sent SHALL be retained.
REQ-016 If in_live falls in the same cycle as PULSE, that cycle's pulse SHALL still be emitted.
- The abort SHALL take effect on the following cycle.
REQ-017 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-018 When rst=1, the block SHALL enter IDLE and clear out_et, out_veto, out_busy, out_done, npulse_sent and all latched parameters to 0.
- rst SHALL take priority over every other input.
REQ-019 A reset during a run SHALL terminate it immediately, with no out_done.

Configuration
REQ-020 Macro DELTA_PULSE_GEN_LFSR_EN:
- When defined, the spacing SHALL be max(gen_period, 2) + lfsr[3:0].
- The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset.
- The LFSR SHALL advance once per PULSE.
- The GAP counter SHALL be 10 bits wide.
- When not defined, the spacing SHALL be fixed per REQ-009 and no LFSR logic SHALL exist.

Structure
REQ-021 Package koto_cdt_pkg SHALL hold:
- ET_W=17 and VETO_W=32
- DELTA_MIN_PERIOD=2
- the FSM state enum
- LFSR_SEED and the LFSR taps
REQ-022 Sub-module delta_pulse_lfsr SHALL be instantiated only under DELTA_PULSE_GEN_LFSR_EN.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Run of 3 pulses: amp=0x0123, ptn=0x0000_0005, period=4, npulse=3, start at cycle 10 -> pulses at cycles 12, 16, 20; out_done at cycle 22; npulse_sent=3.
- Clamp: period=1, npulse=2 -> pulses 2 cycles apart with exactly one zero cycle between them.
- Continuous mode: npulse=0, then user_ena dropped after the 5th pulse -> no 6th pulse, out_done asserted, npulse_sent=5.
- Abort: in_live low during GAP after 2 pulses -> IDLE next cycle, outputs zero, no out_done, npulse_sent=2.
- Restart guard: gen_start pulsed while busy -> no restart and no parameter change; rst mid-run -> all outputs 0 next cycle.
- LFSR_EN build: period=8 -> every spacing lies in 8..23, and the first spacing matches the seed 0xACE1 model.

Source files
------------

// File: rtl/koto_cdt_pkg.sv
// Shared widths, LFSR constants and FSM encoding for the delta pulse generator.
// Macro DELTA_PULSE_GEN_LFSR_EN widens the gap counter to hold the random spacing extension.
package koto_cdt_pkg;
  localparam int ET_W             = 17;
  localparam int AMP_W            = ET_W - 1;
  localparam int VETO_W           = 32;
  localparam int PERIOD_W         = 9;
  localparam int NPULSE_W         = 16;
  localparam int DELTA_MIN_PERIOD = 2;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 written as a mask over bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

`ifdef DELTA_PULSE_GEN_LFSR_EN
  localparam int GAP_W = 10;
`else
  localparam int GAP_W = 9;
`endif

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    PULSE,
    GAP,
    DONE
  } state_t;
endpackage

// File: rtl/delta_pulse_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per emitted pulse; the low nibble
// stretches the pulse spacing when DELTA_PULSE_GEN_LFSR_EN is defined.
module delta_pulse_lfsr
  import koto_cdt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [3:0] rnd
);
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (adv) begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign rnd = lfsr_q[3:0];
endmodule

// File: rtl/delta_pulse_gen.sv
// Delta pulse generator: emits a train of single-cycle ET/veto pulses after a start request.
// Optional macro DELTA_PULSE_GEN_LFSR_EN adds a pseudo-random 0..15 cycle spacing extension.
module delta_pulse_gen
  import koto_cdt_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_live,
  input  logic                user_ena,
  input  logic                gen_start,
  input  logic [AMP_W-1:0]    gen_et_amp,
  input  logic [VETO_W-1:0]   gen_veto_ptn,
  input  logic [PERIOD_W-1:0] gen_period,
  input  logic [NPULSE_W-1:0] gen_npulse,
  output logic [ET_W-1:0]     out_et,
  output logic [VETO_W-1:0]   out_veto,
  output logic                out_busy,
  output logic                out_done,
  output logic [NPULSE_W-1:0] npulse_sent
);
  state_t              state, state_nxt;
  logic [AMP_W-1:0]    amp_q;
  logic [VETO_W-1:0]   ptn_q;
  logic [PERIOD_W-1:0] period_q;
  logic [NPULSE_W-1:0] npulse_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic [PERIOD_W-1:0] period_clamped;
  logic [GAP_W-1:0]    gap_load;
  logic                start_ok;
  logic                count_reached;

  assign start_ok       = (state == IDLE) && gen_start && in_live && user_ena;
  assign count_reached  = (npulse_q != '0) && (npulse_sent >= npulse_q);
  assign period_clamped = (period_q < PERIOD_W'(DELTA_MIN_PERIOD)) ?
                          PERIOD_W'(DELTA_MIN_PERIOD) : period_q;

  // gap_cnt is loaded with spacing-2 so GAP lasts spacing-1 cycles.
`ifdef DELTA_PULSE_GEN_LFSR_EN
  logic [3:0] lfsr_nib;

  delta_pulse_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (state == PULSE),
    .rnd (lfsr_nib)
  );

  assign gap_load = GAP_W'(period_clamped) + GAP_W'(lfsr_nib) - GAP_W'(DELTA_MIN_PERIOD);
`else
  assign gap_load = GAP_W'(period_clamped) - GAP_W'(DELTA_MIN_PERIOD);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = GUARD;
      GUARD: begin
        if (!in_live)       state_nxt = IDLE;
        else if (!user_ena) state_nxt = DONE;
        else                state_nxt = PULSE;
      end
      PULSE: state_nxt = in_live ? GAP : IDLE;
      GAP: begin
        if (!in_live)            state_nxt = IDLE;
        else if (count_reached)  state_nxt = DONE;
        else if (gap_cnt == '0)  state_nxt = user_ena ? PULSE : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      amp_q       <= '0;
      ptn_q       <= '0;
      period_q    <= '0;
      npulse_q    <= '0;
      gap_cnt     <= '0;
      npulse_sent <= '0;
      out_et      <= '0;
      out_veto    <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start_ok) begin
        amp_q       <= gen_et_amp;
        ptn_q       <= gen_veto_ptn;
        period_q    <= gen_period;
        npulse_q    <= gen_npulse;
        npulse_sent <= '0;
      end else if (state_nxt == PULSE && npulse_sent != '1) begin
        npulse_sent <= npulse_sent + NPULSE_W'(1);
      end

      if (state == PULSE) begin
        gap_cnt <= gap_load;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      out_et   <= (state_nxt == PULSE) ? {1'b1, amp_q} : '0;
      out_veto <= (state_nxt == PULSE) ? ptn_q : '0;
      out_busy <= (state_nxt == GUARD) || (state_nxt == PULSE) || (state_nxt == GAP);
      out_done <= (state_nxt == DONE);
    end
  end
endmodule

// File: tb/tb_delta_pulse_gen.sv
// Scoreboard bench for delta_pulse_gen: runs are planned by an arithmetic model,
// expected pulses/done strobes are queued, and a negedge monitor checks them.
module tb_delta_pulse_gen;
  localparam int K_COUNT = 0;
  localparam int K_ENA   = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int          cyc;
    logic [15:0] amp;
    logic [31:0] ptn;
  } pulse_t;

  typedef struct {
    int cyc;
    int sent;
  } done_t;

  logic        clk;
  logic        rst;
  logic        in_live;
  logic        user_ena;
  logic        gen_start;
  logic [15:0] gen_et_amp;
  logic [31:0] gen_veto_ptn;
  logic [8:0]  gen_period;
  logic [15:0] gen_npulse;
  logic [16:0] out_et;
  logic [31:0] out_veto;
  logic        out_busy;
  logic        out_done;
  logic [15:0] npulse_sent;

  int     cyc;
  int     n_pass;
  int     n_total;
  logic   mon_en;
  pulse_t exp_pulse[$];
  done_t  exp_done[$];
  pulse_t mp;
  done_t  md;

`ifdef DELTA_PULSE_GEN_LFSR_EN
  logic [15:0] m_lfsr;
`endif

  delta_pulse_gen dut (
    .clk          (clk),
    .rst          (rst),
    .in_live      (in_live),
    .user_ena     (user_ena),
    .gen_start    (gen_start),
    .gen_et_amp   (gen_et_amp),
    .gen_veto_ptn (gen_veto_ptn),
    .gen_period   (gen_period),
    .gen_npulse   (gen_npulse),
    .out_et       (out_et),
    .out_veto     (out_veto),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .npulse_sent  (npulse_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic scramble();
    gen_et_amp   = 16'($urandom);
    gen_veto_ptn = $urandom;
    gen_period   = 9'($urandom);
    gen_npulse   = 16'($urandom);
  endtask

  // Pulse spacing from the rules: max(period, 2), plus the LFSR nibble in the LFSR build.
  function automatic int model_spacing(input logic [8:0] period);
    int sp;
    sp = (period < 9'd2) ? 2 : int'(period);
`ifdef DELTA_PULSE_GEN_LFSR_EN
    sp += int'(m_lfsr[3:0]);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    return sp;
  endfunction

  // Plans the expected pulses of one run, issues the start, then scrambles gen_* mid-run.
  task automatic run(input logic [15:0] amp, input logic [31:0] ptn, input logic [8:0] period,
                     input logic [15:0] npulse, input int n_emit, input int kind,
                     output int last_p, output int end_c);
    int     t;
    int     sp;
    pulse_t p;
    done_t  d;
    t      = cyc + 2;
    sp     = 2;
    last_p = t;
    for (int k = 0; k < n_emit; k++) begin
      p.cyc = t;
      p.amp = amp;
      p.ptn = ptn;
      exp_pulse.push_back(p);
      last_p = t;
      sp     = model_spacing(period);
      t      = t + sp;
    end
    if (kind == K_COUNT)    end_c = last_p + 2;
    else if (kind == K_ENA) end_c = last_p + sp;
    else                    end_c = last_p + 1;
    if (kind != K_ABORT) begin
      d.cyc  = end_c;
      d.sent = n_emit;
      exp_done.push_back(d);
    end
    gen_et_amp   = amp;
    gen_veto_ptn = ptn;
    gen_period   = period;
    gen_npulse   = npulse;
    gen_start    = 1'b1;
    tick();
    gen_start = 1'b0;
    scramble();
    @(negedge clk);
    check("busy_in_guard", out_busy, 1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_et[16]) begin
        if (exp_pulse.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pulse at cycle %0d: got et %0h, expected no pulse", cyc, out_et);
        end else begin
          mp = exp_pulse.pop_front();
          check("pulse_cycle", cyc, mp.cyc);
          check("pulse_amp", out_et[15:0], mp.amp);
          check("pulse_veto", out_veto, mp.ptn);
        end
      end else begin
        check("quiet_outputs", {out_et, out_veto}, 0);
      end
      if (out_done) begin
        if (exp_done.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done at cycle %0d: got out_done 1, expected 0", cyc);
        end else begin
          md = exp_done.pop_front();
          check("done_cycle", cyc, md.cyc);
          check("done_sent", npulse_sent, md.sent);
          check("busy_in_done", out_busy, 0);
        end
      end
    end
  end

  initial begin
    int lp;
    int ec;
    n_pass       = 0;
    n_total      = 0;
    mon_en       = 1'b0;
`ifdef DELTA_PULSE_GEN_LFSR_EN
    m_lfsr       = 16'hACE1;
`endif
    rst          = 1'b1;
    in_live      = 1'b1;
    user_ena     = 1'b1;
    gen_start    = 1'b1;
    gen_et_amp   = 16'hFFFF;
    gen_veto_ptn = 32'hFFFF_FFFF;
    gen_period   = 9'd3;
    gen_npulse   = 16'd1;

    // Reset held with a start request present: reset must win.
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_et", out_et, 0);
    check("rst_out_veto", out_veto, 0);
    check("rst_out_busy", out_busy, 0);
    check("rst_out_done", out_done, 0);
    check("rst_npulse_sent", npulse_sent, 0);
    tick();
    gen_start = 1'b0;
    rst       = 1'b0;
    mon_en    = 1'b1;

    // Three pulses, period 4, start in cycle 10.
    wait_cyc(10);
    run(16'h0123, 32'h0000_0005, 9'd4, 16'd3, 3, K_COUNT, lp, ec);
    wait_cyc(ec + 2);
    @(negedge clk);
    check("run3_sent", npulse_sent, 3);
    check("run3_idle", out_busy, 0);

    // Period 1 clamps to 2; period 0 as well.
    tick();
    run(16'($urandom), $urandom, 9'd1, 16'd2, 2, K_COUNT, lp, ec);
    wait_cyc(ec + 2);
    run(16'($urandom), $urandom, 9'd0, 16'd3, 3, K_COUNT, lp, ec);
    wait_cyc(ec + 2);

    // Start requests during a run are ignored.
    run(16'h5A5A, 32'hDEAD_BEEF, 9'd3, 16'd3, 3, K_COUNT, lp, ec);
    wait_cyc(lp - 2);
    scramble();
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    wait_cyc(ec + 3);
    @(negedge clk);
    check("restart_sent", npulse_sent, 3);

    // Continuous mode stopped gracefully by user_ena after the 5th pulse.
    tick();
    run(16'($urandom), $urandom, 9'd3, 16'd0, 5, K_ENA, lp, ec);
    wait_cyc(lp + 1);
    user_ena = 1'b0;
    wait_cyc(ec + 2);
    @(negedge clk);
    check("cont_sent", npulse_sent, 5);
    tick();
    user_ena = 1'b1;

    // Abort in GAP after two pulses.
    run(16'($urandom), $urandom, 9'd4, 16'd0, 2, K_ABORT, lp, ec);
    wait_cyc(lp + 1);
    in_live = 1'b0;
    tick();
    @(negedge clk);
    check("abort_gap_busy", out_busy, 0);
    check("abort_gap_done", out_done, 0);
    check("abort_gap_sent", npulse_sent, 2);
    tick();
    tick();
    in_live = 1'b1;
    tick();

    // in_live drops during the pulse cycle: pulse survives, abort follows.
    run(16'($urandom), $urandom, 9'd5, 16'd4, 1, K_ABORT, lp, ec);
    wait_cyc(lp);
    in_live = 1'b0;
    tick();
    @(negedge clk);
    check("abort_pulse_busy", out_busy, 0);
    check("abort_pulse_sent", npulse_sent, 1);
    tick();
    in_live = 1'b1;
    tick();

    // Reset in the middle of a continuous run.
    run(16'($urandom), $urandom, 9'd3, 16'd0, 2, K_ABORT, lp, ec);
    wait_cyc(lp + 1);
    rst = 1'b1;
    tick();
`ifdef DELTA_PULSE_GEN_LFSR_EN
    m_lfsr = 16'hACE1;
`endif
    @(negedge clk);
    check("midrst_et", out_et, 0);
    check("midrst_veto", out_veto, 0);
    check("midrst_busy", out_busy, 0);
    check("midrst_done", out_done, 0);
    check("midrst_sent", npulse_sent, 0);
    tick();
    rst = 1'b0;
    tick();

    // Period 8 right after reset: spacing follows the seeded LFSR in that build.
    run(16'h0F0F, 32'h8000_0001, 9'd8, 16'd4, 4, K_COUNT, lp, ec);
    wait_cyc(ec + 2);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int np;
      np = int'($urandom_range(1, 4));
      run(16'($urandom), $urandom, 9'($urandom_range(0, 12)), 16'(np), np, K_COUNT, lp, ec);
      wait_cyc(ec + 1 + int'($urandom_range(0, 3)));
    end

    repeat (4) tick();
    @(negedge clk);
    check("pulses_outstanding", exp_pulse.size(), 0);
    check("dones_outstanding", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
